// File: rtl/sipo_frame.sv
// Parametrised serial-in/parallel-out deserialiser with a bit-valid qualifier,
// a handshaked word holding register, synchronous clear and a sticky overrun flag.
module sipo_frame #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_vld,
  input  logic                     clr,
  input  logic                     par_rdy,
  output logic [WIDTH-1:0]         par_out,
  output logic                     par_vld,
  output logic                     overrun,
  output logic [WIDTH-1:0]         shreg,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_vld_q, par_vld_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             lastBit;
  logic             slotFree;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[WIDTH-2:0], ser_in};
    end else begin : g_lsb
      assign shifted = {ser_in, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign lastBit  = (cnt_q == LAST_CNT);
  // A held word consumed on this edge frees the slot for a word completing on the same edge.
  assign slotFree = ~par_vld_q | par_rdy;

  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_out_d = par_out_q;
    par_vld_d = par_vld_q;
    ovr_d     = ovr_q;
    if (par_vld_q && par_rdy) begin
      par_vld_d = 1'b0;
    end
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (ser_vld) begin
      shreg_d = shifted;
      cnt_d   = lastBit ? '0 : cnt_q + CW'(1);
      if (lastBit) begin
        if (slotFree) begin
          par_out_d = shifted;
          par_vld_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_out_q <= '0;
      par_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_out_q <= par_out_d;
      par_vld_q <= par_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign shreg   = shreg_q;
  assign bit_cnt = cnt_q;
  assign par_out = par_out_q;
  assign par_vld = par_vld_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_frame.sv
// Directed bench for sipo_frame: a vector table drives an LSB-first instance,
// and a short hand-written sequence exercises an MSB-first instance.
module tb_sipo_frame;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       ser_vld;
  logic       clr;
  logic       par_rdy;
  logic [3:0] parOut0, parOut1;
  logic       parVld0, parVld1;
  logic       ovr0, ovr1;
  logic [3:0] sh0, sh1;
  logic [1:0] cnt0, cnt1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0] stim;
    logic [3:0] expPar;
    logic       expVld;
    logic       expOvr;
    logic [3:0] expSh;
    logic [1:0] expCnt;
  } vec_t;

  vec_t vecs[$];

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_vld(ser_vld), .clr(clr),
    .par_rdy(par_rdy), .par_out(parOut0), .par_vld(parVld0), .overrun(ovr0),
    .shreg(sh0), .bit_cnt(cnt0)
  );

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_vld(ser_vld), .clr(clr),
    .par_rdy(par_rdy), .par_out(parOut1), .par_vld(parVld1), .overrun(ovr1),
    .shreg(sh1), .bit_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addRow(input logic [4:0] stim, input logic [3:0] par, input logic vld,
                        input logic ovr, input logic [3:0] sh, input logic [1:0] cnt);
    vec_t v;
    v.stim = stim; v.expPar = par; v.expVld = vld; v.expOvr = ovr;
    v.expSh = sh; v.expCnt = cnt;
    vecs.push_back(v);
  endtask

  // stim = {rst_n, ser_in, ser_vld, clr, par_rdy}; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic [4:0] stim);
    {rst_n, ser_in, ser_vld, clr, par_rdy} = stim;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  initial begin
    {rst_n, ser_in, ser_vld, clr, par_rdy} = 5'b0_0_0_0_1;

    addRow(5'b0_0_0_0_1, 4'b0000, 0, 0, 4'b0000, 2'd0);
    addRow(5'b1_1_1_0_1, 4'b0000, 0, 0, 4'b1000, 2'd1);
    addRow(5'b1_0_1_0_1, 4'b0000, 0, 0, 4'b0100, 2'd2);
    addRow(5'b1_1_1_0_1, 4'b0000, 0, 0, 4'b1010, 2'd3);
    addRow(5'b1_1_1_0_1, 4'b1101, 1, 0, 4'b1101, 2'd0);
    addRow(5'b1_0_0_0_1, 4'b1101, 0, 0, 4'b1101, 2'd0);
    addRow(5'b1_1_1_0_1, 4'b1101, 0, 0, 4'b1110, 2'd1);
    addRow(5'b1_0_1_0_1, 4'b1101, 0, 0, 4'b0111, 2'd2);
    addRow(5'b1_0_0_0_1, 4'b1101, 0, 0, 4'b0111, 2'd2);
    addRow(5'b1_1_0_0_1, 4'b1101, 0, 0, 4'b0111, 2'd2);
    addRow(5'b1_0_0_0_1, 4'b1101, 0, 0, 4'b0111, 2'd2);
    addRow(5'b1_1_1_0_1, 4'b1101, 0, 0, 4'b1011, 2'd3);
    addRow(5'b1_1_1_0_1, 4'b1101, 1, 0, 4'b1101, 2'd0);
    addRow(5'b1_0_0_0_1, 4'b1101, 0, 0, 4'b1101, 2'd0);
    addRow(5'b1_1_1_0_0, 4'b1101, 0, 0, 4'b1110, 2'd1);
    addRow(5'b1_0_1_0_0, 4'b1101, 0, 0, 4'b0111, 2'd2);
    addRow(5'b1_1_1_0_0, 4'b1101, 0, 0, 4'b1011, 2'd3);
    addRow(5'b1_1_1_0_0, 4'b1101, 1, 0, 4'b1101, 2'd0);
    addRow(5'b1_0_1_0_0, 4'b1101, 1, 0, 4'b0110, 2'd1);
    addRow(5'b1_0_1_0_0, 4'b1101, 1, 0, 4'b0011, 2'd2);
    addRow(5'b1_0_1_0_0, 4'b1101, 1, 0, 4'b0001, 2'd3);
    addRow(5'b1_0_1_0_0, 4'b1101, 1, 1, 4'b0000, 2'd0);
    addRow(5'b1_0_0_1_0, 4'b1101, 1, 0, 4'b0000, 2'd0);
    addRow(5'b1_0_1_0_0, 4'b1101, 1, 0, 4'b0000, 2'd1);
    addRow(5'b1_1_1_0_0, 4'b1101, 1, 0, 4'b1000, 2'd2);
    addRow(5'b1_1_1_0_0, 4'b1101, 1, 0, 4'b1100, 2'd3);
    addRow(5'b1_0_1_0_1, 4'b0110, 1, 0, 4'b0110, 2'd0);
    addRow(5'b1_1_1_0_1, 4'b0110, 0, 0, 4'b1011, 2'd1);
    addRow(5'b1_1_1_0_1, 4'b0110, 0, 0, 4'b1101, 2'd2);
    addRow(5'b0_1_1_0_1, 4'b0000, 0, 0, 4'b0000, 2'd0);
    addRow(5'b1_0_1_0_1, 4'b0000, 0, 0, 4'b0000, 2'd1);
    addRow(5'b1_1_1_0_1, 4'b0000, 0, 0, 4'b1000, 2'd2);
    addRow(5'b1_0_1_0_1, 4'b0000, 0, 0, 4'b0100, 2'd3);
    addRow(5'b1_0_1_0_1, 4'b0010, 1, 0, 4'b0010, 2'd0);
    addRow(5'b1_1_1_0_1, 4'b0010, 0, 0, 4'b1001, 2'd1);
    addRow(5'b1_1_1_0_1, 4'b0010, 0, 0, 4'b1100, 2'd2);
    addRow(5'b1_1_1_1_1, 4'b0010, 0, 0, 4'b0000, 2'd0);
    addRow(5'b1_0_1_0_1, 4'b0010, 0, 0, 4'b0000, 2'd1);
    addRow(5'b1_1_1_0_1, 4'b0010, 0, 0, 4'b1000, 2'd2);
    addRow(5'b1_0_1_0_1, 4'b0010, 0, 0, 4'b0100, 2'd3);
    addRow(5'b1_0_1_0_1, 4'b0010, 1, 0, 4'b0010, 2'd0);
    addRow(5'b1_0_0_1_1, 4'b0010, 0, 0, 4'b0000, 2'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("row%0d.par_out", i), parOut0, vecs[i].expPar);
      checkOutput($sformatf("row%0d.par_vld", i), {3'b0, parVld0}, {3'b0, vecs[i].expVld});
      checkOutput($sformatf("row%0d.overrun", i), {3'b0, ovr0}, {3'b0, vecs[i].expOvr});
      checkOutput($sformatf("row%0d.shreg", i), sh0, vecs[i].expSh);
      checkOutput($sformatf("row%0d.bit_cnt", i), {2'b0, cnt0}, {2'b0, vecs[i].expCnt});
    end

    // MSB-first instance: bits 1,0,1,1 after a reset edge.
    applyStimulus(5'b0_0_0_0_1);
    checkOutput("msb.reset.shreg", sh1, 4'b0000);
    checkOutput("msb.reset.par_vld", {3'b0, parVld1}, 4'b0000);
    applyStimulus(5'b1_1_1_0_1);
    checkOutput("msb.b1.shreg", sh1, 4'b0001);
    applyStimulus(5'b1_0_1_0_1);
    checkOutput("msb.b2.shreg", sh1, 4'b0010);
    applyStimulus(5'b1_1_1_0_1);
    checkOutput("msb.b3.shreg", sh1, 4'b0101);
    checkOutput("msb.b3.par_vld", {3'b0, parVld1}, 4'b0000);
    applyStimulus(5'b1_1_1_0_1);
    checkOutput("msb.b4.shreg", sh1, 4'b1011);
    checkOutput("msb.b4.par_out", parOut1, 4'b1011);
    checkOutput("msb.b4.par_vld", {3'b0, parVld1}, 4'b0001);
    checkOutput("msb.b4.bit_cnt", {2'b0, cnt1}, 4'b0000);
    checkOutput("msb.b4.overrun", {3'b0, ovr1}, 4'b0000);

    // Repeated overruns keep the flag set while the held word stays intact.
    repeat (4) applyStimulus(5'b1_0_1_0_0);
    checkOutput("msb.ovr1.overrun", {3'b0, ovr1}, 4'b0001);
    repeat (4) applyStimulus(5'b1_1_1_0_0);
    checkOutput("msb.ovr2.overrun", {3'b0, ovr1}, 4'b0001);
    checkOutput("msb.ovr2.par_out", parOut1, 4'b1011);
    checkOutput("msb.ovr2.shreg", sh1, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
